// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the generic pipeline stage register: skid FSM state
// encoding, occupancy width and the state-to-occupancy decode.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_t;

    localparam int PIPE_OCC_W = 2;

    function automatic logic [PIPE_OCC_W-1:0] occ_of(input pipe_state_t s);
        logic [PIPE_OCC_W-1:0] occ;
        occ = PIPE_OCC_W'(0);
        case (s)
            PS_ONE:  occ = PIPE_OCC_W'(1);
            PS_TWO:  occ = PIPE_OCC_W'(2);
            default: occ = PIPE_OCC_W'(0);
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid stage: main entry feeds the output, skid entry absorbs the
// payload accepted in the cycle downstream stalls. in_ready is a flop.
module pipe_skid_buffer
    import pipe_stage_reg_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WIDTH-1:0]      in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WIDTH-1:0]      out_data_o,
    output logic [PIPE_OCC_W-1:0] occupancy_o
);

    pipe_state_t      state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             accept;
    logic             pop;

    assign accept = in_valid_i & in_ready_q;
    assign pop    = out_valid_q & out_ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PS_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush_i) begin
            // Entries are dropped but payload registers keep their contents.
            state_q     <= PS_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                PS_EMPTY: begin
                    if (accept) begin
                        main_q      <= in_data_i;
                        out_valid_q <= 1'b1;
                        state_q     <= PS_ONE;
                    end
                end
                PS_ONE: begin
                    case ({accept, pop})
                        2'b10: begin
                            skid_q     <= in_data_i;
                            in_ready_q <= 1'b0;
                            state_q    <= PS_TWO;
                        end
                        2'b01: begin
                            out_valid_q <= 1'b0;
                            state_q     <= PS_EMPTY;
                        end
                        2'b11: begin
                            main_q <= in_data_i;
                        end
                        default: ;
                    endcase
                end
                PS_TWO: begin
                    if (pop) begin
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                        state_q    <= PS_ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= PS_EMPTY;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_q;
    assign occupancy_o = occ_of(state_q);

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush,
// optional two-entry skid mode and a saturating stall counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SKID  = 0,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [PIPE_OCC_W-1:0] occupancy,
    output logic [CNT_W-1:0]      stall_count
);

    generate
        if (SKID == 0) begin : g_single
            logic             valid_q;
            logic             valid_d;
            logic [WIDTH-1:0] data_q;
            logic [WIDTH-1:0] data_d;
            logic             accept;

            // Ready may follow out_ready combinationally: a pop frees the slot.
            assign in_ready = ~valid_q | out_ready;
            assign accept   = in_valid & in_ready;

            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                if (flush) begin
                    valid_d = 1'b0;
                end else if (accept) begin
                    valid_d = 1'b1;
                    data_d  = in_data;
                end else if (out_ready) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            assign out_valid = valid_q;
            assign out_data  = data_q;
            assign occupancy = {{(PIPE_OCC_W-1){1'b0}}, valid_q};
        end else begin : g_skid
            pipe_skid_buffer #(
                .WIDTH(WIDTH)
            ) u_skid (
                .clk         (clk),
                .reset       (reset),
                .flush_i     (flush),
                .in_valid_i  (in_valid),
                .in_ready_o  (in_ready),
                .in_data_i   (in_data),
                .out_valid_o (out_valid),
                .out_ready_i (out_ready),
                .out_data_o  (out_data),
                .occupancy_o (occupancy)
            );
        end
    endgenerate

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;

    // Saturating, and deliberately blind to flush so stalls survive mispredicts.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a single-entry (CNT_W=3) and a skid instance run
// side by side against a queue-based reference with a pop scoreboard.
module tb_pipe_stage_reg;

    localparam int WIDTH = 16;
    localparam int N     = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset     [N];
    logic             flush     [N];
    logic             in_valid  [N];
    logic             in_ready  [N];
    logic [WIDTH-1:0] in_data   [N];
    logic             out_valid [N];
    logic             out_ready [N];
    logic [WIDTH-1:0] out_data  [N];
    logic [1:0]       occupancy [N];

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h want %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        localparam int SK = gi;
        localparam int CW = (gi == 0) ? 3 : 16;

        logic [CW-1:0] stall_w;

        pipe_stage_reg #(
            .WIDTH(WIDTH),
            .SKID (SK),
            .CNT_W(CW)
        ) dut (
            .clk        (clk),
            .reset      (reset[gi]),
            .flush      (flush[gi]),
            .in_valid   (in_valid[gi]),
            .in_ready   (in_ready[gi]),
            .in_data    (in_data[gi]),
            .out_valid  (out_valid[gi]),
            .out_ready  (out_ready[gi]),
            .out_data   (out_data[gi]),
            .occupancy  (occupancy[gi]),
            .stall_count(stall_w)
        );

        // Reference: held entries as a FIFO of capacity 1 or 2.
        logic [WIDTH-1:0] mdl_q[$];
        logic [WIDTH-1:0] exp_q[$];
        logic [WIDTH-1:0] hold_data = '0;
        int               stall_m   = 0;

        function automatic bit model_ready(input int sz, input bit ordy);
            if (SK == 0) return (sz == 0) || ordy;
            return sz < 2;
        endfunction

        always @(posedge clk) begin : model
            bit acc;
            bit pop;
            if (reset[gi]) begin
                mdl_q.delete();
                exp_q.delete();
                hold_data = '0;
                stall_m   = 0;
            end else begin
                if (mdl_q.size() > 0 && !out_ready[gi] && stall_m < (2**CW - 1))
                    stall_m++;
                if (flush[gi]) begin
                    mdl_q.delete();
                    exp_q.delete();
                end else begin
                    acc = in_valid[gi] && model_ready(mdl_q.size(), out_ready[gi]);
                    pop = (mdl_q.size() > 0) && out_ready[gi];
                    if (pop) void'(mdl_q.pop_front());
                    if (acc) begin
                        mdl_q.push_back(in_data[gi]);
                        exp_q.push_back(in_data[gi]);
                    end
                end
                if (mdl_q.size() > 0) hold_data = mdl_q[0];
            end
        end

        always @(negedge clk) begin : monitor
            logic [WIDTH-1:0] exp_d;
            logic [WIDTH-1:0] sb_d;
            if (checking) begin
                exp_d = (mdl_q.size() > 0) ? mdl_q[0] : hold_data;
                chk("out_valid", gi, 32'(out_valid[gi]), 32'(mdl_q.size() > 0));
                chk("in_ready", gi, 32'(in_ready[gi]), 32'(model_ready(mdl_q.size(), out_ready[gi])));
                chk("occupancy", gi, 32'(occupancy[gi]), 32'(mdl_q.size()));
                chk("out_data", gi, 32'(out_data[gi]), 32'(exp_d));
                chk("stall_count", gi, 32'(stall_w), 32'(stall_m));
                if (out_valid[gi] && out_ready[gi] && !flush[gi] && !reset[gi]) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", gi, 32'(out_data[gi]), 32'hFFFF_FFFF);
                    end else begin
                        sb_d = exp_q.pop_front();
                        chk("sb_pop", gi, 32'(out_data[gi]), 32'(sb_d));
                        $display("dut%0d pop data=%h expected=%h t=%0t", gi, out_data[gi], sb_d, $time);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rv, input bit fl, input bit iv, input logic [WIDTH-1:0] d, input bit ordy);
        for (int k = 0; k < N; k++) begin
            reset[k]     = rv;
            flush[k]     = fl;
            in_valid[k]  = iv;
            in_data[k]   = d;
            out_ready[k] = ordy;
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        cyc();
        checking = 1'b1;
        cyc();

        // Back-to-back stream with the sink always ready
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b0, 1'b1, 16'(i), 1'b1);
            cyc();
        end
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        repeat (2) cyc();

        // Backpressure: two payloads, hold, then drain
        drive(1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 1'b1, 16'hBBBB, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        repeat (5) cyc();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        repeat (3) cyc();

        // Flush while full, with a payload offered in the flush cycle
        drive(1'b0, 1'b0, 1'b1, 16'h1111, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 1'b1, 16'h2222, 1'b0);
        cyc();
        drive(1'b0, 1'b1, 1'b1, 16'hCCCC, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        repeat (2) cyc();

        // Simultaneous pop and accept
        drive(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 1'b1, 16'h5678, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        repeat (2) cyc();

        // Long stall: the 3-bit counter must saturate at 7
        drive(1'b0, 1'b0, 1'b1, 16'h0042, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 1'b1, 16'h0043, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        repeat (10) cyc();

        // Reset and flush together while full
        drive(1'b1, 1'b1, 1'b1, 16'h7777, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        repeat (2) cyc();

        // Randomised traffic with occasional flush and reset
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < N; k++) begin
                in_valid[k]  = ($urandom_range(0, 3) != 0);
                in_data[k]   = 16'($urandom);
                out_ready[k] = ($urandom_range(0, 2) != 0);
                flush[k]     = ($urandom_range(0, 40) == 0);
                reset[k]     = ($urandom_range(0, 300) == 0);
            end
            cyc();
        end

        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        repeat (4) cyc();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
